sha3_digest_streamer: RTL and testbench

//  Sits directly downstream of the SHA-3 core top level and consumes its squeeze output.

---
 rtl/sha3_digest_streamer_if.sv | 36 +++
 rtl/sha3_digest_streamer.sv | 112 +++++++++++
 tb/tb_sha3_digest_streamer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sha3_digest_streamer_if.sv
// Handshake bundle between the SHA-3 squeeze stage, this streamer and the word sink.
// slave  : the streamer side (consumes blocks, produces words)
// master : the environment side (produces blocks, consumes words)
interface sha3_digest_streamer_if #(
   parameter int BLOCK_W = 1344,
   parameter int W       = 64,
   parameter int LEN_W   = 11
);
   // block capture side
   logic [BLOCK_W-1:0] in_data;
   logic               in_valid;
   logic [LEN_W-1:0]   in_length;
   logic [1:0]         in_mode;
   logic               in_finish;
   // word stream side
   logic [W-1:0]       o_data;
   logic               o_valid;
   logic               o_ready;
   logic               o_last;
   logic [3:0]         o_nbytes;
   logic [1:0]         o_mode;
   // status
   logic               busy;
   logic               err_ovf;
   logic               err_len;

   modport slave (
      input  in_data, in_valid, in_length, in_mode, in_finish, o_ready,
      output o_data, o_valid, o_last, o_nbytes, o_mode, busy, err_ovf, err_len
   );

   modport master (
      output in_data, in_valid, in_length, in_mode, in_finish, o_ready,
      input  o_data, o_valid, o_last, o_nbytes, o_mode, busy, err_ovf, err_len
   );
endinterface

// File: rtl/sha3_digest_streamer.sv
// Captures one right-aligned squeeze block and streams it MSB-first as W-bit words.
// The block is left-justified into a shift buffer at capture so every word is
// simply the top W bits; a remaining-bit counter marks the last word.
module sha3_digest_streamer #(
   parameter int BLOCK_W = 1344,
   parameter int W       = 64,
   parameter int LEN_W   = 11
) (
   input  logic                    clk,
   input  logic                    rst,
   sha3_digest_streamer_if.slave   bus
);

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

   localparam logic [LEN_W-1:0] BLK_LEN = LEN_W'(BLOCK_W);
   localparam logic [LEN_W-1:0] W_LEN   = LEN_W'(W);
   localparam logic [3:0]       W_BYTES = 4'(W / 8);

   state_e              state_q, state_d;
   logic [BLOCK_W-1:0]  buf_q, buf_d;
   logic [LEN_W-1:0]    rem_q, rem_d;
   logic [1:0]          mode_q, mode_d;
   logic                fin_q, fin_d;
   logic                ovf_q, ovf_d;
   logic                elen_q, elen_d;

   logic                last_word;
   logic                hs;
   logic                last_hs;
   logic                len_ok;
   logic                cap;
   logic [LEN_W-1:0]    shamt;
   logic [LEN_W:0]      rem_p7;

   // Handshake and capture qualification
   always_comb begin
      last_word = (rem_q <= W_LEN);
      hs        = (state_q == SEND) && bus.o_ready;
      last_hs   = hs && last_word;
      len_ok    = (bus.in_length != '0) && (bus.in_length <= BLK_LEN);
      // a new block may land on the same edge the old one finishes (no bubble)
      cap       = bus.in_valid && len_ok && ((state_q == IDLE) || last_hs);
      shamt     = BLK_LEN - bus.in_length;
      rem_p7    = {1'b0, rem_q} + (LEN_W+1)'(7);
   end

   // Next-state: word advance, block capture, sticky error flags
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      rem_d   = rem_q;
      mode_d  = mode_q;
      fin_d   = fin_q;
      ovf_d   = ovf_q;
      elen_d  = elen_q;

      if (hs) begin
         buf_d = buf_q << W;
         rem_d = last_word ? '0 : (rem_q - W_LEN);
         if (last_word) state_d = IDLE;
      end

      // capture wins over the advance above when both happen on the last word
      if (cap) begin
         buf_d   = bus.in_data << shamt;
         rem_d   = bus.in_length;
         mode_d  = bus.in_mode;
         fin_d   = bus.in_finish;
         state_d = SEND;
      end

      if (bus.in_valid && !len_ok) elen_d = 1'b1;
      // legal block that could not be captured: buffer was still busy
      if (bus.in_valid && len_ok && !cap) ovf_d = 1'b1;
   end

   // State and datapath registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         buf_q   <= '0;
         rem_q   <= '0;
         mode_q  <= '0;
         fin_q   <= 1'b0;
         ovf_q   <= 1'b0;
         elen_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         rem_q   <= rem_d;
         mode_q  <= mode_d;
         fin_q   <= fin_d;
         ovf_q   <= ovf_d;
         elen_q  <= elen_d;
      end
   end

   // Outputs come straight from registers so they hold steady during stalls
   always_comb begin
      bus.busy     = (state_q == SEND);
      bus.o_valid  = (state_q == SEND);
      bus.o_data   = (state_q == SEND) ? buf_q[BLOCK_W-1 -: W] : '0;
      bus.o_last   = (state_q == SEND) && fin_q && last_word;
      bus.o_mode   = (state_q == SEND) ? mode_q : 2'b00;
      bus.o_nbytes = 4'b0000;
      if (state_q == SEND) bus.o_nbytes = last_word ? 4'(rem_p7 >> 3) : W_BYTES;
      bus.err_ovf  = ovf_q;
      bus.err_len  = elen_q;
   end

endmodule

// File: tb/tb_sha3_digest_streamer.sv
// Directed bench for sha3_digest_streamer: drives blocks on the falling edge,
// samples words on the falling edge, expected words taken bit-by-bit from in_data.
module tb_sha3_digest_streamer;
   localparam int BLOCK_W = 1344;
   localparam int W       = 64;
   localparam int LEN_W   = 11;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sha3_digest_streamer_if #(.BLOCK_W(BLOCK_W), .W(W), .LEN_W(LEN_W)) bus ();

   sha3_digest_streamer #(.BLOCK_W(BLOCK_W), .W(W), .LEN_W(LEN_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [BLOCK_W-1:0] exp_blk;
   int                 ch_len;
   bit                 ch_fin;
   logic [1:0]         ch_mode;
   logic [BLOCK_W-1:0] ch_data;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [BLOCK_W-1:0] mk(input int seed);
      logic [BLOCK_W-1:0] r;
      for (int i = 0; i < BLOCK_W / 64; i++)
         r[64*i +: 64] = {8'(seed), 8'(i), 48'h1234_5678_9abc ^ 48'(seed * 977 + i * 131)};
      return r;
   endfunction

   // word j of a block = in_data[len-1-64j -: 64], zero below bit 0
   function automatic logic [63:0] exp_word(input int len, input int j);
      logic [63:0] w;
      int          idx;
      for (int b = 0; b < 64; b++) begin
         idx = len - 1 - 64 * j - b;
         w[63-b] = (idx >= 0) ? exp_blk[idx] : 1'b0;
      end
      return w;
   endfunction

   task automatic drive_blk(input int len, input bit fin, input logic [1:0] mode,
                            input logic [BLOCK_W-1:0] d);
      bus.in_valid  = 1'b1;
      bus.in_data   = d;
      bus.in_length = LEN_W'(len);
      bus.in_finish = fin;
      bus.in_mode   = mode;
   endtask

   task automatic pulse(input int len, input bit fin, input logic [1:0] mode,
                        input logic [BLOCK_W-1:0] d);
      drive_blk(len, fin, mode, d);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   // Walks one block's words; inj_at injects an overflow block, chain captures
   // the ch_* block on the last-word handshake.
   task automatic collect(input int len, input bit fin, input logic [1:0] mode,
                          input bit rnd, input int inj_at, input bit chain);
      int nw  = (len + W - 1) / W;
      int j   = 0;
      int cyc = 0;
      bit injd = 0;
      bit r;
      while (j < nw && cyc < 3000) begin
         chk("o_valid",  64'(bus.o_valid), 64'(1));
         chk("o_data",   bus.o_data, exp_word(len, j));
         chk("o_last",   64'(bus.o_last), 64'(fin && j == nw - 1));
         chk("o_nbytes", 64'(bus.o_nbytes), 64'((j == nw - 1) ? (len - W * j + 7) / 8 : W / 8));
         chk("o_mode",   64'(bus.o_mode), 64'(mode));
         r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (j == inj_at && !injd) begin
            r = 1'b0;
            injd = 1;
            drive_blk(BLOCK_W, 1'b1, 2'd3, mk(99));
         end
         if (chain && j == nw - 1) begin
            r = 1'b1;
            drive_blk(ch_len, ch_fin, ch_mode, ch_data);
         end
         bus.o_ready = r;
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.o_ready  = 1'b0;
         if (r) j++;
         cyc++;
      end
      if (cyc >= 3000) chk("timeout", 64'(0), 64'(1));
      if (!chain) begin
         chk("idle_valid", 64'(bus.o_valid), 64'(0));
         chk("idle_busy",  64'(bus.busy),    64'(0));
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"},  64'(bus.o_valid),  64'(0));
      chk({tag, "_busy"},   64'(bus.busy),     64'(0));
      chk({tag, "_data"},   bus.o_data,        64'(0));
      chk({tag, "_last"},   64'(bus.o_last),   64'(0));
      chk({tag, "_nbytes"}, 64'(bus.o_nbytes), 64'(0));
      chk({tag, "_mode"},   64'(bus.o_mode),   64'(0));
      chk({tag, "_ovf"},    64'(bus.err_ovf),  64'(0));
      chk({tag, "_elen"},   64'(bus.err_len),  64'(0));
   endtask

   initial begin
      rst           = 1'b0;
      bus.in_data   = '0;
      bus.in_valid  = 1'b0;
      bus.in_length = '0;
      bus.in_mode   = '0;
      bus.in_finish = 1'b0;
      bus.o_ready   = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero("rst");
      rst = 1'b1;
      @(negedge clk);

      // 1: 256 bits, finish, sink always ready
      exp_blk = mk(1);
      pulse(256, 1'b1, 2'd1, exp_blk);
      collect(256, 1'b1, 2'd1, 1'b0, -1, 1'b0);

      // 2: full 1344-bit block with random stalls
      exp_blk = mk(2);
      pulse(1344, 1'b0, 2'd2, exp_blk);
      collect(1344, 1'b0, 2'd2, 1'b1, -1, 1'b0);

      // 3: 200 bits -> partial last word of one byte
      exp_blk = mk(3);
      pulse(200, 1'b1, 2'd3, exp_blk);
      chk("t3_w0", bus.o_data, exp_blk[199 -: 64]);
      collect(200, 1'b1, 2'd3, 1'b0, -1, 1'b0);
      chk("t3_ovf", 64'(bus.err_ovf), 64'(0));

      // 4: overflow while word index 2 pending
      exp_blk = mk(4);
      pulse(1344, 1'b0, 2'd0, exp_blk);
      collect(1344, 1'b0, 2'd0, 1'b0, 2, 1'b0);
      chk("t4_ovf", 64'(bus.err_ovf), 64'(1));
      @(negedge clk);
      chk("t4_noextra", 64'(bus.o_valid), 64'(0));

      // 5: back-to-back capture on the last-word handshake
      exp_blk = mk(5);
      ch_len  = 192;
      ch_fin  = 1'b1;
      ch_mode = 2'd2;
      ch_data = mk(6);
      pulse(128, 1'b0, 2'd1, exp_blk);
      collect(128, 1'b0, 2'd1, 1'b0, -1, 1'b1);
      exp_blk = ch_data;
      collect(192, 1'b1, 2'd2, 1'b0, -1, 1'b0);

      // 6: reset mid-block clears everything, then a clean block streams
      exp_blk = mk(7);
      pulse(1344, 1'b0, 2'd3, exp_blk);
      bus.o_ready = 1'b1;
      repeat (2) @(negedge clk);
      bus.o_ready = 1'b0;
      chk("t6_pre_busy", 64'(bus.busy), 64'(1));
      rst = 1'b0;
      @(negedge clk);
      chk_zero("t6rst");
      rst = 1'b1;
      exp_blk = mk(8);
      pulse(320, 1'b1, 2'd3, exp_blk);
      collect(320, 1'b1, 2'd3, 1'b0, -1, 1'b0);

      // zero length: ignored, flagged
      pulse(0, 1'b1, 2'd1, mk(9));
      chk("t6_len0_elen",  64'(bus.err_len), 64'(1));
      chk("t6_len0_valid", 64'(bus.o_valid), 64'(0));
      chk("t6_len0_ovf",   64'(bus.err_ovf), 64'(0));

      // oversize length: ignored, flagged (fresh reset so the flag is observable)
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("t6_rst2_elen", 64'(bus.err_len), 64'(0));
      pulse(1345, 1'b0, 2'd1, mk(10));
      chk("t6_big_elen",  64'(bus.err_len), 64'(1));
      chk("t6_big_valid", 64'(bus.o_valid), 64'(0));
      @(negedge clk);
      chk("t6_big_busy",  64'(bus.busy),    64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
